// File: rtl/cfu_li1_initiator.sv
// Purpose: CPU-side level-1 CFU initiator; issues commands, checks response slots, buffers results in order.
// Latency: command accepted in cycle t -> result on res_* in cycle t+CFU_RESP_LATENCY+1 (empty FIFO).
// Backpressure: cmd_ready drops unless FIFO space is reserved for every in-flight response; res_* is ready/valid.
module cfu_li1_initiator #(
    parameter int CFU_FUNC_ID_W    = 5,
    parameter int CFU_REQ_DATA_W   = 32,
    parameter int CFU_RESP_DATA_W  = 32,
    parameter int CFU_ERR_ID_W     = 32,
    parameter int CFU_RESP_LATENCY = 3,
    parameter int RES_DEPTH        = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [CFU_FUNC_ID_W-1:0]   cmd_func_id,
    input  logic [CFU_REQ_DATA_W-1:0]  cmd_data0,
    input  logic [CFU_REQ_DATA_W-1:0]  cmd_data1,
    output logic                       req_valid,
    output logic [CFU_FUNC_ID_W-1:0]   req_func_id,
    output logic [CFU_REQ_DATA_W-1:0]  req_data0,
    output logic [CFU_REQ_DATA_W-1:0]  req_data1,
    input  logic                       resp_valid,
    input  logic [CFU_RESP_DATA_W-1:0] resp_data,
    input  logic                       resp_err,
    input  logic [CFU_ERR_ID_W-1:0]    resp_err_id,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [CFU_RESP_DATA_W-1:0] res_data,
    output logic                       res_err,
    output logic [CFU_ERR_ID_W-1:0]    res_err_id,
    output logic [4:0]                 inflight,
    output logic                       lat_err
);

    localparam int          PTR_W   = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int          CNT_W   = $clog2(RES_DEPTH) + 1;
    localparam logic [31:0] DEPTH_U = RES_DEPTH;

    typedef struct packed {
        logic [CFU_RESP_DATA_W-1:0] data;
        logic                       err;
        logic [CFU_ERR_ID_W-1:0]    err_id;
    } res_entry_t;

    logic [CFU_RESP_LATENCY-1:0] slot_q, slot_d;
    logic [4:0]                  inflight_q, inflight_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        lat_err_q, lat_err_d;
    res_entry_t                  mem_q [RES_DEPTH];

    logic                        expected;
    logic                        push;
    logic                        pop;
    logic [31:0]                 occupancy;
    res_entry_t                  push_entry;

    // Space is committed at issue time: buffered results plus every response still on its way.
    assign occupancy   = 32'(count_q) + 32'(inflight_q);
    assign cmd_ready   = !rst && (occupancy < DEPTH_U);
    assign req_valid   = cmd_valid && cmd_ready;
    assign req_func_id = cmd_func_id;
    assign req_data0   = cmd_data0;
    assign req_data1   = cmd_data1;

    // The oldest slot bit marks the cycle in which a response must arrive.
    assign expected = slot_q[CFU_RESP_LATENCY-1];
    assign push     = expected;
    assign pop      = res_ready && (count_q != '0);

    assign res_valid  = (count_q != '0);
    assign res_data   = mem_q[rd_ptr_q].data;
    assign res_err    = mem_q[rd_ptr_q].err;
    assign res_err_id = mem_q[rd_ptr_q].err_id;
    assign inflight   = inflight_q;
    assign lat_err    = lat_err_q;

    // Next-state: slot shift, inflight bookkeeping, FIFO pointers and the sticky protocol flag.
    always_comb begin
        slot_d     = slot_q << 1;
        slot_d[0]  = req_valid;
        inflight_d = inflight_q + 5'(req_valid) - 5'(expected);
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        // A due slot without a response, or a response without a due slot, are both protocol errors.
        lat_err_d  = lat_err_q | (expected ^ resp_valid);
        if (resp_valid) begin
            push_entry.data   = resp_data;
            push_entry.err    = resp_err;
            push_entry.err_id = resp_err_id;
        end else begin
            push_entry.data   = '0;
            push_entry.err    = 1'b1;
            push_entry.err_id = '1;
        end
    end

    // Control state register with synchronous reset; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q     <= '0;
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lat_err_q  <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lat_err_q  <= lat_err_d;
        end
    end

    // Result storage; contents are only meaningful below count_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Issue gating must make an overflowing push impossible; catch any hole in that reasoning.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && (count_q == CNT_W'(RES_DEPTH))))
                else $error("result FIFO overflow");
        end
    end

endmodule
